mips_alu_arbiter: RTL and testbench
===================================

MIPS_ALU_ARBITER -- requirements
Module: mips_alu_arbiter

Interface
REQ-001 Parameters (one per line):
- WIDTH, 8, operand/result width.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset.
REQ-003 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_ctl  in  4  requester 0 ALU control code
- req1_valid / req1_ready / req1_a / req1_b / req1_ctl  same as requester 0, for requester 1
- rsp_valid  out  1  result held on rsp_* outputs
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index of result
- rsp_out  out  WIDTH  ALU result
- rsp_zero  out  1  rsp_out == 0
- rsp_err  out  1  control code was illegal
- busy  out  1  state != IDLE

Function
REQ-004 The block SHALL share one ALU instance between two requesters using a three-state FSM: IDLE, EXEC, HOLD.
REQ-005 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, latch a/b/ctl/id, go EXEC; otherwise stay in IDLE.
REQ-006 Never more than one reqN_ready high per cycle; reqN_ready SHALL be 0 outside IDLE.
REQ-007 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history; after reset requester 0 has priority.
REQ-008 EXEC: ALU SHALL evaluate latched operands; at the end of the cycle register rsp_out/rsp_zero/rsp_err/rsp_id, go HOLD.
REQ-009 HOLD: rsp_valid=1 and rsp_* stable; on rsp_ready=1 go IDLE; rsp_ready=0 holds indefinitely.
REQ-010 Latency: accept at cycle N -> rsp_valid at N+2; minimum issue interval 3 cycles.
REQ-011 Legal ctl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-012 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT SHALL compare signed (two's complement) and return 1 or 0 zero-extended.
REQ-013 Illegal ctl: rsp_out=0, rsp_zero=0, rsp_err=1; the transaction otherwise completes normally.
REQ-014 rsp_zero SHALL equal (rsp_out==0) for legal codes.
REQ-015 reqN_valid changes outside a granted cycle SHALL have no effect; operands latched at grant are immune to later input changes.

Reset
REQ-016 On rst_n low, asynchronously: state=IDLE, rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_err=0, rsp_id=0, busy=0, last-grant=1 (requester 0 favoured).
REQ-017 Reset in EXEC or HOLD SHALL discard the in-flight operation without producing a response.
REQ-018 After rst_n deasserts, the first grant SHALL occur on the first rising clk edge with a valid request.

Structure
REQ-019 A shared package SHALL hold the six ALU control-code constants and the FSM state enumeration.
REQ-020 The block SHALL instantiate the existing mipsALU as its single sub-module; the arbiter adds no arithmetic of its own beyond the illegal-code override.

Verification
REQ-021 req0 ADD a=0x22 b=0x0B -> rsp_out=0x2D, rsp_zero=0, rsp_id=0, rsp_valid two cycles after accept.
REQ-022 Both valid from reset: req0 SUB 0x0C,0x03 then req1 NOR 0x07,0x11 -> first 0x09 id 0, then 0xE8 id 1; a second simultaneous pair is served req0 first again.
REQ-023 ADD 0xFF,0x01 -> rsp_out=0x00, rsp_zero=1; SLT 0x80,0x01 -> 0x01; SLT 0x35,0x19 -> 0x00, rsp_zero=1.
REQ-024 rsp_ready held 0 for 10 cycles with AND 0x01,0x03 -> rsp_out=0x01 stable, reqN_ready stays 0, busy=1 throughout.
REQ-025 ctl=0011 -> rsp_err=1, rsp_out=0x00, rsp_zero=0; next legal op clears rsp_err.
REQ-026 rst_n pulsed low during EXEC -> rsp_valid never rises for that op; the next request completes normally with requester 0 priority.

Source files
------------

// File: rtl/mips_alu_arbiter_pkg.sv
// mips_alu_arbiter_pkg: ALU control codes, arbiter FSM states and control-code legality check
package mips_alu_arbiter_pkg;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
  function automatic logic ctl_legal(input logic [3:0] c);
    return c inside {CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR};
  endfunction
endpackage

// File: rtl/mipsALU.sv
// mipsALU: combinational MIPS ALU (AND/OR/ADD/SUB/SLT/NOR) with zero flag
module mipsALU
  import mips_alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);
  logic lt;
  always_comb begin
    lt = $signed(a) < $signed(b);
    alu_out = alu_ctl == CTL_AND ? a & b :
              alu_ctl == CTL_OR  ? a | b :
              alu_ctl == CTL_ADD ? a + b :
              alu_ctl == CTL_SUB ? a - b :
              alu_ctl == CTL_SLT ? {{(WIDTH-1){1'b0}}, lt} :
              alu_ctl == CTL_NOR ? ~(a | b) : '0;
    zero = alu_out == '0;
  end
endmodule

// File: rtl/mips_alu_arbiter.sv
// mips_alu_arbiter: round-robin arbiter sharing one mipsALU between two requesters (IDLE/EXEC/HOLD)
module mips_alu_arbiter
  import mips_alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);
  state_e state_q, state_d;
  logic last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rsp_out_q, rsp_out_d, alu_out;
  logic [3:0] ctl_q, ctl_d;
  logic gnt0, gnt1, alu_zero, legal;
  mipsALU #(.WIDTH(WIDTH)) u_alu (
    .alu_ctl (ctl_q),
    .a       (a_q),
    .b       (b_q),
    .alu_out (alu_out),
    .zero    (alu_zero)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    ctl_d = ctl_q;
    rsp_out_d = rsp_out_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d = rsp_id_q;
    gnt1 = req1_valid && (!req0_valid || !last_q);
    gnt0 = req0_valid && !gnt1;
    req0_ready = state_q == IDLE && gnt0;
    req1_ready = state_q == IDLE && gnt1;
    legal = ctl_legal(ctl_q);
    if (req0_ready || req1_ready) begin
      state_d = EXEC;
      last_d = gnt1;
      id_d = gnt1;
      a_d = gnt1 ? req1_a : req0_a;
      b_d = gnt1 ? req1_b : req0_b;
      ctl_d = gnt1 ? req1_ctl : req0_ctl;
    end
    if (state_q == EXEC) begin
      state_d = HOLD;
      rsp_out_d = legal ? alu_out : '0;
      rsp_zero_d = legal && alu_zero;
      rsp_err_d = !legal;
      rsp_id_d = id_q;
    end
    if (state_q == HOLD && rsp_ready) state_d = IDLE;
    rsp_valid = state_q == HOLD;
    busy = state_q != IDLE;
    rsp_out = rsp_out_q;
    rsp_zero = rsp_zero_q;
    rsp_err = rsp_err_q;
    rsp_id = rsp_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      rsp_out_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      ctl_q <= ctl_d;
      rsp_out_q <= rsp_out_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_mips_alu_arbiter.sv
// tb_mips_alu_arbiter: directed self-checking bench for mips_alu_arbiter
module tb_mips_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_ctl = '0, req1_ctl = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic [7:0] rsp_out;
  int errors = 0, checks = 0;
  mips_alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set0(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    req0_valid = 1'b1; req0_ctl = c; req0_a = a; req0_b = b;
  endtask
  task automatic set1(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    req1_valid = 1'b1; req1_ctl = c; req1_a = a; req1_b = b;
  endtask
  task automatic serve(input string tag, input logic id, input logic [7:0] out, input logic z, input logic e, input int hold);
    #1;
    check({tag, ":rdy0"}, 32'(req0_ready), 32'(!id));
    check({tag, ":rdy1"}, 32'(req1_ready), 32'(id));
    @(posedge clk); @(negedge clk);
    if (id) begin req1_valid = 1'b0; req1_a = ~req1_a; req1_b = ~req1_b; req1_ctl = 4'b0011; end
    else begin req0_valid = 1'b0; req0_a = ~req0_a; req0_b = ~req0_b; req0_ctl = 4'b0011; end
    #1;
    check({tag, ":exec_busy"}, 32'(busy), 32'd1);
    check({tag, ":exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":exec_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
    @(negedge clk);
    check({tag, ":valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ":out"}, 32'(rsp_out), 32'(out));
    check({tag, ":zero"}, 32'(rsp_zero), 32'(z));
    check({tag, ":err"}, 32'(rsp_err), 32'(e));
    check({tag, ":id"}, 32'(rsp_id), 32'(id));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_out"}, 32'(rsp_out), 32'(out));
      check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":hold_busy"}, 32'(busy), 32'd1);
      check({tag, ":hold_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":done_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(rsp_out), 32'd0);
    check("rst_flags", {29'd0, rsp_zero, rsp_err, rsp_id}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("idle_rdy", 32'(req0_ready | req1_ready), 32'd0);
    @(negedge clk);
    set0(4'b0110, 8'h0C, 8'h03);
    set1(4'b1100, 8'h07, 8'h11);
    serve("pair1_sub", 1'b0, 8'h09, 1'b0, 1'b0, 0);
    serve("pair1_nor", 1'b1, 8'hE8, 1'b0, 1'b0, 0);
    set0(4'b0010, 8'h22, 8'h0B);
    set1(4'b0110, 8'h05, 8'h07);
    serve("pair2_add", 1'b0, 8'h2D, 1'b0, 1'b0, 0);
    serve("pair2_sub", 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    set0(4'b0010, 8'hFF, 8'h01);
    serve("add_wrap", 1'b0, 8'h00, 1'b1, 1'b0, 0);
    set0(4'b0111, 8'h80, 8'h01);
    serve("slt_neg", 1'b0, 8'h01, 1'b0, 1'b0, 0);
    set1(4'b0111, 8'h35, 8'h19);
    serve("slt_pos", 1'b1, 8'h00, 1'b1, 1'b0, 0);
    set0(4'b0000, 8'h01, 8'h03);
    set1(4'b0010, 8'h10, 8'h20);
    serve("and_hold", 1'b0, 8'h01, 1'b0, 1'b0, 10);
    serve("after_hold", 1'b1, 8'h30, 1'b0, 1'b0, 0);
    set0(4'b0011, 8'hA5, 8'h5A);
    serve("illegal", 1'b0, 8'h00, 1'b0, 1'b1, 0);
    set0(4'b0001, 8'h50, 8'h05);
    serve("or_clear", 1'b0, 8'h55, 1'b0, 1'b0, 0);
    set0(4'b0110, 8'h44, 8'h04);
    #1;
    check("abort_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    check("abort_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_busy", 32'(busy), 32'd0);
    check("abort_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set0(4'b0001, 8'h0F, 8'hF0);
    set1(4'b0010, 8'h10, 8'h20);
    serve("post_rst_or", 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    serve("post_rst_add", 1'b1, 8'h30, 1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
